modcnt_checker: RTL and testbench
=================================

MODCNT_CHECKER -- requirements
Module: modcnt_checker

Interface
REQ-001 Parameter N, default 8: modulus of the monitored count stream, legal 2..16.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct successors required to declare lock, legal 1..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_vld  input  1  sample qualifier; in_cnt is ignored when low.
REQ-006 in_cnt  input  4  count value from a mod-N up-counter; in range when value < N.
REQ-007 clr  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  level; high while the FSM is in LOCKED.
REQ-009 err  output  1  one-cycle pulse per sequence error detected while locked.
REQ-010 wrap  output  1  one-cycle pulse per correct N-1 -> 0 transition while locked.
REQ-011 err_cnt  output  8  saturating error count.
REQ-012 expected  output  4  next value predicted from the last accepted sample.

Function
REQ-013 Successor rule: succ(p) = 0 when p == N-1, else p+1.
REQ-014 FSM states: HUNT, TRACK, LOCKED.
REQ-015 Internal registers: prev (4 bits, last accepted sample) and match (4 bits, count of correct successors).
REQ-016 With in_vld low: no state, prev, match or err_cnt change; err and wrap are low.
REQ-017 HUNT, valid in-range sample: prev = sample, match = 0, go to TRACK.
REQ-018 HUNT, valid out-of-range sample: stay in HUNT.
REQ-019 TRACK, sample == succ(prev): prev = sample, match += 1.
REQ-020 TRACK: when match reaches LOCK_CNT on that sample, go to LOCKED and set match = 0.
REQ-021 TRACK, in-range sample != succ(prev): prev = sample, match = 0, stay in TRACK, no err pulse.
REQ-022 TRACK, out-of-range sample: go to HUNT, no err pulse.
REQ-023 LOCKED, sample == succ(prev): prev = sample, stay in LOCKED.
REQ-024 LOCKED, correct sample with prev == N-1 and sample == 0: wrap pulses high.
REQ-025 LOCKED, in-range sample != succ(prev): err pulse, err_cnt += 1, prev = sample, match = 0, go to TRACK.
REQ-026 LOCKED, out-of-range sample: err pulse, err_cnt += 1, go to HUNT.
REQ-027 err, wrap and locked are registered and change the cycle after the clock edge that samples the triggering input (latency 1).
REQ-028 expected = succ(prev), registered; it is 0 in HUNT.
REQ-029 err_cnt saturates at 255 and does not wrap.
REQ-030 clr with no error in the same cycle: err_cnt = 0 on the next edge.
REQ-031 clr and an error in the same cycle: err_cnt = 1.
REQ-032 N == 16: every 4-bit value is in range, so the out-of-range paths are unreachable.
REQ-033 LOCK_CNT == 1: a single correct successor causes lock.

Reset
REQ-034 rstn low at a clock edge: state = HUNT; prev, match, expected, err_cnt = 0; locked, err, wrap = 0.
REQ-035 Reset overrides all other inputs, including clr and in_vld.
REQ-036 Reset applies from any state, including mid-lock.
REQ-037 The first valid sample after reset release is handled by HUNT.

Verification
REQ-038 N=8, LOCK_CNT=3, continuous samples 5,6,7,0 -> locked rises the cycle after sample 0; no err.
REQ-039 Locked stream ...6,7,0,1 -> single wrap pulse the cycle after 0; err_cnt unchanged.
REQ-040 Locked, stream 2,3,5 -> err pulse one cycle after 5; err_cnt=1; locked falls; then 6,7,0 -> relock.
REQ-041 Locked, sample 9 -> err pulse, state HUNT, locked=0, expected=0; next sample 4 -> TRACK.
REQ-042 err_cnt at 255, another error -> stays 255; clr with simultaneous error -> err_cnt=1.
REQ-043 in_vld gaps inside 1,_,2,_,3,_,4 -> lock still achieved; rstn low while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/modcnt_checker.sv
// Checks a mod-N counter stream: hunts for an in-range value, tracks correct
// successors until LOCK_CNT are seen, then flags sequence errors and wraps while locked.
module modcnt_checker #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_vld,
  input  logic [3:0] in_cnt,
  input  logic       clr,
  output logic       locked,
  output logic       err,
  output logic       wrap,
  output logic [7:0] err_cnt,
  output logic [3:0] expected
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] match_q, match_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] expected_q, expected_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;
  logic       in_range, succ_ok, err_now;
  logic [3:0] match_inc;

  function automatic logic [3:0] succ(input logic [3:0] p);
    return (p == 4'(N - 1)) ? 4'd0 : p + 4'd1;
  endfunction

  assign in_range  = {1'b0, in_cnt} < 5'(N);
  assign succ_ok   = (in_cnt == succ(prev_q));
  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    err_now = 1'b0;
    if (in_vld) begin
      case (state_q)
        HUNT: begin
          if (in_range) begin
            prev_d  = in_cnt;
            match_d = 4'd0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (!in_range) begin
            state_d = HUNT;
          end else if (succ_ok) begin
            prev_d = in_cnt;
            if (match_inc >= 4'(LOCK_CNT)) begin
              match_d = 4'd0;
              state_d = LOCKED;
            end else begin
              match_d = match_inc;
            end
          end else begin
            prev_d  = in_cnt;
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!in_range) begin
            err_now = 1'b1;
            state_d = HUNT;
          end else if (succ_ok) begin
            prev_d = in_cnt;
            wrap_d = (in_cnt == 4'd0);
          end else begin
            err_now = 1'b1;
            prev_d  = in_cnt;
            match_d = 4'd0;
            state_d = TRACK;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    err_d = err_now;

    // An error in the same cycle as clr counts as the first error after clearing.
    err_cnt_d = err_cnt_q;
    if (clr)                               err_cnt_d = err_now ? 8'd1 : 8'd0;
    else if (err_now && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    expected_d = (state_d == HUNT) ? 4'd0 : succ(prev_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= HUNT;
      prev_q     <= 4'd0;
      match_q    <= 4'd0;
      err_cnt_q  <= 8'd0;
      expected_q <= 4'd0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      err_cnt_q  <= err_cnt_d;
      expected_q <= expected_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign wrap     = wrap_q;
  assign err_cnt  = err_cnt_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_modcnt_checker.sv
// Directed bench for modcnt_checker at N=8, LOCK_CNT=3.
module tb_modcnt_checker;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_vld = 1'b0;
  logic [3:0] in_cnt = 4'd0;
  logic       clr = 1'b0;
  logic       locked, err, wrap;
  logic [7:0] err_cnt;
  logic [3:0] expected;

  int checks = 0;
  int errors = 0;

  modcnt_checker #(.N(8), .LOCK_CNT(3)) dut (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_cnt(in_cnt), .clr(clr),
    .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt), .expected(expected)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input logic v, input logic [3:0] c, input logic cl = 1'b0);
    @(negedge clk);
    in_vld = v; in_cnt = c; clr = cl;
    @(posedge clk);
    #1;
    in_vld = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(1'b1, 4'd3, 1'b1);
    step(1'b1, 4'd4, 1'b0);
    checks++;
    if ({locked, err, wrap, err_cnt, expected} !== 15'd0) begin
      errors++;
      $display("FAIL reset: got l=%0b e=%0b w=%0b cnt=%0d exp=%0d, need all 0",
               locked, err, wrap, err_cnt, expected);
    end
    rstn = 1'b1;
  endtask

  task automatic test_lock();
    logic [3:0] seq [4];
    seq = '{4'd5, 4'd6, 4'd7, 4'd0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq[i]);
      checks++;
      if (locked !== 1'b0 || expected !== ((seq[i] + 4'd1) & 4'd7)) begin
        errors++;
        $display("FAIL lock_pre%0d: got l=%0b exp=%0d, need l=0 exp=%0d",
                 i, locked, expected, (seq[i] + 4'd1) & 4'd7);
      end
    end
    step(1'b1, seq[3]);
    checks++;
    if (locked !== 1'b1 || err !== 1'b0 || expected !== 4'd1) begin
      errors++;
      $display("FAIL lock: got l=%0b e=%0b exp=%0d, need l=1 e=0 exp=1", locked, err, expected);
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    for (int v = 1; v <= 7; v++) begin
      step(1'b1, 4'(v));
      if (wrap) wraps++;
    end
    step(1'b1, 4'd0);
    checks++;
    if (wrap !== 1'b1 || wraps != 0) begin
      errors++;
      $display("FAIL wrap_pulse: got wrap=%0b early=%0d, need wrap=1 early=0", wrap, wraps);
    end
    step(1'b1, 4'd1);
    checks++;
    if (wrap !== 1'b0 || err_cnt !== 8'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrap_after: got wrap=%0b cnt=%0d l=%0b, need 0 0 1", wrap, err_cnt, locked);
    end
  endtask

  task automatic test_err();
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    step(1'b1, 4'd5);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || expected !== 4'd6) begin
      errors++;
      $display("FAIL seq_err: got e=%0b cnt=%0d l=%0b exp=%0d, need 1 1 0 6",
               err, err_cnt, locked, expected);
    end
    step(1'b1, 4'd6);
    checks++;
    if (err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got e=%0b l=%0b, need 0 0", err, locked);
    end
    step(1'b1, 4'd7);
    step(1'b1, 4'd0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL relock: got l=%0b cnt=%0d, need 1 1", locked, err_cnt);
    end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 4'd9);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0 || expected !== 4'd0) begin
      errors++;
      $display("FAIL oor: got e=%0b cnt=%0d l=%0b exp=%0d, need 1 2 0 0",
               err, err_cnt, locked, expected);
    end
    step(1'b1, 4'd4);
    checks++;
    if (err !== 1'b0 || locked !== 1'b0 || expected !== 4'd5) begin
      errors++;
      $display("FAIL oor_track: got e=%0b l=%0b exp=%0d, need 0 0 5", err, locked, expected);
    end
  endtask

  task automatic test_gaps();
    rstn = 1'b0;
    step(1'b0, 4'd0);
    rstn = 1'b1;
    step(1'b1, 4'd1);
    step(1'b0, 4'd6);
    checks++;
    if (expected !== 4'd2 || locked !== 1'b0) begin
      errors++;
      $display("FAIL gap_hold: got exp=%0d l=%0b, need 2 0", expected, locked);
    end
    step(1'b1, 4'd2);
    step(1'b0, 4'd9);
    step(1'b1, 4'd3);
    step(1'b0, 4'd0);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL gap_early: got l=%0b e=%0b, need 0 0", locked, err);
    end
    step(1'b1, 4'd4);
    checks++;
    if (locked !== 1'b1 || expected !== 4'd5) begin
      errors++;
      $display("FAIL gap_lock: got l=%0b exp=%0d, need 1 5", locked, expected);
    end
    rstn = 1'b0;
    step(1'b1, 4'd7, 1'b0);
    checks++;
    if ({locked, err, wrap, err_cnt, expected} !== 15'd0) begin
      errors++;
      $display("FAIL reset_locked: got l=%0b e=%0b w=%0b cnt=%0d exp=%0d, need all 0",
               locked, err, wrap, err_cnt, expected);
    end
    rstn = 1'b1;
  endtask

  task automatic test_saturate();
    logic [3:0] p, bad;
    int sat_bad = 0;
    rstn = 1'b0;
    step(1'b0, 4'd0);
    rstn = 1'b1;
    for (int v = 0; v < 4; v++) step(1'b1, 4'(v));
    p = 4'd3;
    for (int i = 1; i <= 256; i++) begin
      bad = (p + 4'd2) & 4'd7;
      step(1'b1, bad);
      if (err_cnt !== 8'((i > 255) ? 255 : i)) sat_bad++;
      for (int k = 1; k <= 3; k++) step(1'b1, (bad + 4'(k)) & 4'd7);
      p = (bad + 4'd3) & 4'd7;
    end
    checks++;
    if (sat_bad != 0 || err_cnt !== 8'd255 || locked !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d l=%0b steps_wrong=%0d, need 255 1 0",
               err_cnt, locked, sat_bad);
    end
    bad = (p + 4'd2) & 4'd7;
    step(1'b1, bad, 1'b1);
    checks++;
    if (err_cnt !== 8'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL clr_err: got cnt=%0d e=%0b, need 1 1", err_cnt, err);
    end
    step(1'b0, 4'd0, 1'b1);
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr: got cnt=%0d, need 0", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_err();
    test_out_of_range();
    test_gaps();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
